// File: rtl/decode_stage.sv
// decode_stage
// Registered RV32I decode stage with a valid/ready handshake and a one-entry
// skid buffer. Decodes register addresses, enables, the sign-extended
// immediate and the instruction format, and flags unsupported opcodes.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous flush, drops every buffered record
//   in_valid/in_ready upstream handshake; in_ready comes straight from a flop
//   instruction,in_pc raw instruction word and its PC
//   out_valid/out_ready downstream handshake
//   out_pc            passed-through PC
//   rs1_addr,rs2_addr,rd_addr  register addresses (0 when unused)
//   rs1_en,rs2_en,rd_wen       source-used / destination-write flags
//   imm               sign-extended immediate
//   fmt               R=0 I=1 S=2 B=3 U=4 J=5 none=7
//   illegal           unsupported opcode
module decode_stage #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction,
   input  logic [XLEN-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [REG_AW-1:0] rs1_addr,
   output logic [REG_AW-1:0] rs2_addr,
   output logic [REG_AW-1:0] rd_addr,
   output logic              rs1_en,
   output logic              rs2_en,
   output logic              rd_wen,
   output logic [XLEN-1:0]   imm,
   output logic [2:0]        fmt,
   output logic              illegal
);

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              rs1_en;
      logic              rs2_en;
      logic              rd_wen;
      logic [XLEN-1:0]   imm;
      fmt_e              fmt;
      logic              illegal;
   } rec_t;

   rec_t dec;
   rec_t main_q, main_d, skid_q, skid_d;
   logic main_v_q, main_v_d, skid_v_q, skid_v_d;

   logic        use_rs1, use_rs2, use_rd;
   logic [31:0] imm32;
   logic        accept, consume;

   // ---------------- combinational decode ----------------
   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      imm32   = '0;
      dec     = '0;
      dec.pc  = in_pc;
      dec.fmt = FMT_NONE;
      dec.illegal = 1'b1;

      case (instruction[6:0])
         7'b0110011: begin
            dec.fmt = FMT_R;
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
         end
         7'b0010011, 7'b0000011, 7'b1100111: begin
            dec.fmt = FMT_I;
            use_rs1 = 1'b1; use_rd = 1'b1;
            imm32 = {{20{instruction[31]}}, instruction[31:20]};
         end
         7'b0100011: begin
            dec.fmt = FMT_S;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         end
         7'b1100011: begin
            dec.fmt = FMT_B;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec.fmt = FMT_U;
            use_rd = 1'b1;
            imm32 = {instruction[31:12], 12'b0};
         end
         7'b1101111: begin
            dec.fmt = FMT_J;
            use_rd = 1'b1;
            imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};
         end
         default: ;
      endcase

      dec.illegal = (dec.fmt == FMT_NONE);
      dec.rs1     = use_rs1 ? REG_AW'(instruction[19:15]) : '0;
      dec.rs2     = use_rs2 ? REG_AW'(instruction[24:20]) : '0;
      dec.rd      = use_rd  ? REG_AW'(instruction[11:7])  : '0;
      dec.rs1_en  = use_rs1;
      dec.rs2_en  = use_rs2;
      dec.rd_wen  = use_rd && (instruction[11:7] != 5'd0);
      // All formats are built at 32 bits; the signed cast widens to XLEN.
      dec.imm     = XLEN'($signed(imm32));
   end

   // ---------------- handshake / storage ----------------
   assign accept  = in_valid & ~skid_v_q;
   assign consume = main_v_q & out_ready;

   always_comb begin
      main_d   = main_q;
      skid_d   = skid_q;
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (consume) begin
         // skid valid implies in_ready=0, so no accept can coincide here
         if (skid_v_q) begin
            main_d   = skid_q;
            main_v_d = 1'b1;
            skid_v_d = 1'b0;
         end else if (accept) begin
            main_d   = dec;
            main_v_d = 1'b1;
         end else begin
            main_v_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_v_q) begin
            main_d   = dec;
            main_v_d = 1'b1;
         end else begin
            skid_d   = dec;
            skid_v_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
      end
   end

   assign in_ready  = ~skid_v_q;
   assign out_valid = main_v_q;
   assign out_pc    = main_q.pc;
   assign rs1_addr  = main_q.rs1;
   assign rs2_addr  = main_q.rs2;
   assign rd_addr   = main_q.rd;
   assign rs1_en    = main_q.rs1_en;
   assign rs2_en    = main_q.rs2_en;
   assign rd_wen    = main_q.rd_wen;
   assign imm       = main_q.imm;
   assign fmt       = main_q.fmt;
   assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (XLEN=32, REG_AW=5).
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        rs1_en, rs2_en, rd_wen;
   logic [31:0] imm;
   logic [2:0]  fmt;
   logic        illegal;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rd_addr     (rd_addr),
      .rs1_en      (rs1_en),
      .rs2_en      (rs2_en),
      .rd_wen      (rd_wen),
      .imm         (imm),
      .fmt         (fmt),
      .illegal     (illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one edge and sample 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      in_valid    = v;
      instruction = ins;
      in_pc       = pc;
   endtask

   task automatic expect_rec(input string tag,
                             input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                             input logic [4:0] e_rd, input logic e_rs1_en,
                             input logic e_rs2_en, input logic e_rd_wen,
                             input logic [31:0] e_imm, input logic [2:0] e_fmt,
                             input logic e_ill, input logic [31:0] e_pc);
      chk({tag, ".valid"},  out_valid, 1'b1);
      chk({tag, ".rs1"},    rs1_addr,  e_rs1);
      chk({tag, ".rs2"},    rs2_addr,  e_rs2);
      chk({tag, ".rd"},     rd_addr,   e_rd);
      chk({tag, ".rs1_en"}, rs1_en,    e_rs1_en);
      chk({tag, ".rs2_en"}, rs2_en,    e_rs2_en);
      chk({tag, ".rd_wen"}, rd_wen,    e_rd_wen);
      chk({tag, ".imm"},    imm,       e_imm);
      chk({tag, ".fmt"},    fmt,       e_fmt);
      chk({tag, ".ill"},    illegal,   e_ill);
      chk({tag, ".pc"},     out_pc,    e_pc);
   endtask

   task automatic expect_zero(input string tag);
      chk({tag, ".valid"},  out_valid, 1'b0);
      chk({tag, ".ready"},  in_ready,  1'b1);
      chk({tag, ".pc"},     out_pc,    32'h0);
      chk({tag, ".addrs"},  {rs1_addr, rs2_addr, rd_addr}, 15'h0);
      chk({tag, ".ens"},    {rs1_en, rs2_en, rd_wen}, 3'b000);
      chk({tag, ".imm"},    imm,       32'h0);
      chk({tag, ".fmt"},    fmt,       3'd0);
      chk({tag, ".ill"},    illegal,   1'b0);
   endtask

   localparam logic [31:0] ADDI = 32'hFFF10093; // addi x1,x2,-1
   localparam logic [31:0] SW   = 32'h00532423; // sw x5,8(x6)
   localparam logic [31:0] BEQ  = 32'hFE000EE3; // beq x0,x0,-4
   localparam logic [31:0] JAL  = 32'h001000EF; // jal x1,2048
   localparam logic [31:0] ADD  = 32'h002081B3; // add x3,x1,x2
   localparam logic [31:0] LUI  = 32'hABCDE2B7; // lui x5,0xABCDE
   localparam logic [31:0] NOP  = 32'h00000013; // addi x0,x0,0

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);

      // ---- reset state ----
      tick(); tick();
      expect_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      #2;

      // ---- single-instruction decode, back-to-back at full throughput ----
      drive(1'b1, ADDI, 32'h100); tick();
      expect_rec("addi", 5'd2, 5'd0, 5'd1, 1, 0, 1, 32'hFFFFFFFF, 3'd1, 0, 32'h100);
      drive(1'b1, SW, 32'h104); tick();
      expect_rec("sw", 5'd6, 5'd5, 5'd0, 1, 1, 0, 32'h00000008, 3'd2, 0, 32'h104);
      drive(1'b1, BEQ, 32'h108); tick();
      expect_rec("beq", 5'd0, 5'd0, 5'd0, 1, 1, 0, 32'hFFFFFFFC, 3'd3, 0, 32'h108);
      drive(1'b1, JAL, 32'h10C); tick();
      expect_rec("jal", 5'd0, 5'd0, 5'd1, 0, 0, 1, 32'h00000800, 3'd5, 0, 32'h10C);
      drive(1'b1, 32'h0, 32'h110); tick();
      expect_rec("zero", 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0, 3'd7, 1, 32'h110);
      drive(1'b1, ADD, 32'h114); tick();
      expect_rec("add", 5'd1, 5'd2, 5'd3, 1, 1, 1, 32'h0, 3'd0, 0, 32'h114);
      drive(1'b1, LUI, 32'h118); tick();
      expect_rec("lui", 5'd0, 5'd0, 5'd5, 0, 0, 1, 32'hABCDE000, 3'd4, 0, 32'h118);
      drive(1'b1, NOP, 32'h11C); tick();
      expect_rec("nop_x0", 5'd0, 5'd0, 5'd0, 1, 0, 0, 32'h0, 3'd1, 0, 32'h11C);
      drive(1'b0, 32'h0, 32'h0); tick();
      chk("drain.valid", out_valid, 1'b0);

      // ---- stall: A in main, B in skid, C held ----
      out_ready = 1'b0;
      drive(1'b1, ADDI, 32'h200); tick();
      chk("stallA.pc", out_pc, 32'h200);
      chk("stallA.ready", in_ready, 1'b1);
      drive(1'b1, SW, 32'h204); tick();
      chk("stallB.pc", out_pc, 32'h200);
      chk("stallB.ready", in_ready, 1'b0);
      drive(1'b1, JAL, 32'h208); tick();
      chk("stallC.pc", out_pc, 32'h200);
      chk("stallC.imm", imm, 32'hFFFFFFFF);
      chk("stallC.ready", in_ready, 1'b0);
      chk("stallC.valid", out_valid, 1'b1);
      out_ready = 1'b1; tick();
      expect_rec("relB", 5'd6, 5'd5, 5'd0, 1, 1, 0, 32'h00000008, 3'd2, 0, 32'h204);
      chk("relB.ready", in_ready, 1'b1);
      tick();
      expect_rec("relC", 5'd0, 5'd0, 5'd1, 0, 0, 1, 32'h00000800, 3'd5, 0, 32'h208);
      drive(1'b0, 32'h0, 32'h0); tick();
      chk("relEnd.valid", out_valid, 1'b0);

      // ---- flush with both entries full ----
      out_ready = 1'b0;
      drive(1'b1, ADDI, 32'h300); tick();
      drive(1'b1, SW, 32'h304); tick();
      chk("fullF.ready", in_ready, 1'b0);
      flush = 1'b1; drive(1'b1, BEQ, 32'h308); tick();
      flush = 1'b0; drive(1'b0, 32'h0, 32'h0);
      chk("flushF.valid", out_valid, 1'b0);
      chk("flushF.ready", in_ready, 1'b1);
      tick();
      chk("flushF2.valid", out_valid, 1'b0);

      // ---- flush discards a same-cycle accept (in_ready high) ----
      drive(1'b1, ADDI, 32'h310); tick();
      chk("flushH.pre", out_valid, 1'b1);
      flush = 1'b1; drive(1'b1, JAL, 32'h314); tick();
      flush = 1'b0; drive(1'b0, 32'h0, 32'h0);
      chk("flushH.valid", out_valid, 1'b0);
      chk("flushH.ready", in_ready, 1'b1);
      tick();
      chk("flushH2.valid", out_valid, 1'b0);
      chk("flushH2.skid", in_ready, 1'b1);

      // ---- asynchronous reset mid-stall ----
      drive(1'b1, ADDI, 32'h400); tick();
      drive(1'b1, SW, 32'h404); tick();
      drive(1'b0, 32'h0, 32'h0);
      chk("arst.pre_ready", in_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.valid_now", out_valid, 1'b0);
      chk("arst.ready_now", in_ready, 1'b1);
      tick();
      @(negedge clk) rst_n = 1'b1;
      tick();
      expect_zero("arst.after");
      out_ready = 1'b1;
      drive(1'b1, LUI, 32'h500); tick();
      expect_rec("resume", 5'd0, 5'd0, 5'd5, 0, 0, 1, 32'hABCDE000, 3'd4, 0, 32'h500);
      drive(1'b0, 32'h0, 32'h0); tick();
      chk("resume.drain", out_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I instruction decode stage with a valid/ready handshake and a one-entry skid buffer. Extracts register addresses, write/read enables, and the fully sign-extended immediate for all base formats (R/I/S/B/U/J), and flags illegal opcodes. Sits between fetch and register-file read/execute. Gives the core a one-cycle decode pipeline stage that tolerates downstream stalls without bubbles.

## Interface
- XLEN, 32, datapath/immediate/PC width; legal values ≥ 32
- REG_AW, 5, register address width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous flush; drops all buffered entries
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept this cycle
- instruction  input  32  raw instruction word
- in_pc  input  XLEN  PC of instruction, passed through
- out_valid  output  1  decoded record valid
- out_ready  input  1  downstream accepts record
- out_pc  output  XLEN  passed-through PC
- rs1_addr, rs2_addr, rd_addr  output  REG_AW each  register addresses
- rs1_en, rs2_en, rd_wen  output  1 each  source-used / destination-write flags
- imm  output  XLEN  sign-extended immediate
- fmt  output  3  R=0, I=1, S=2, B=3, U=4, J=5, none=7
- illegal  output  1  unsupported opcode

## Operation
- Opcode decode (instruction[6:0]):
  - 0110011 → R
  - 0010011, 0000011, 1100111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - anything else → illegal=1, fmt=7, all addresses/enables/imm = 0
- Field use per format:
  - rs1 in R/I/S/B
  - rs2 in R/S/B
  - rd in R/I/U/J
  - Unused address fields output 0 with enable 0.
  - rd_wen=0 when rd_addr==0.
- Immediates, sign bit is instruction[31], sign-extended to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R: imm = 0
- Storage: main register (drives outputs) plus one skid register, each holding a full decoded record and a valid bit.
  - in_ready = ~skid_valid, driven from a register with no combinational path from out_ready.
  - Accept = in_valid & in_ready. An accepted instruction goes to main if main is empty or main is being consumed this cycle; otherwise it goes to skid.
  - Main is consumed when out_valid & out_ready. On consume with skid valid: main ← skid and skid empties; in_ready rises next cycle.
  - Simultaneous accept and consume with skid empty: main ← new record; no bubble.
  - Order is strictly FIFO. No record is dropped or duplicated.
- flush: both valid bits clear at the next edge and any same-cycle accept is discarded. Flush has priority over accept and consume.
- Record contents are don't-care while valid=0, but must be held stable while out_valid=1 and out_ready=0.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs with out_valid=1 after edge N.
- Throughput: 1 instruction per cycle while out_ready=1.
- Reset (async assert, sync to clk on release):
  - out_valid=0, skid_valid=0, in_ready=1
  - all address, enable, imm and out_pc fields = 0
  - fmt=0, illegal=0
- Reset mid-stall: all buffered entries are lost and in_ready returns to 1.
- Full condition: main and skid both valid → in_ready=0 until the first consume edge.
- in_valid while in_ready=0 is ignored. Upstream holds the instruction.

## Test plan
- Send 0xFFF10093 (addi x1,x2,-1), out_ready=1 → next cycle: rs1=2, rd=1, rd_wen=1, imm=0xFFFFFFFF, fmt=1, illegal=0.
- Send 0x00532423 (sw x5,8(x6)) → rs1=6, rs2=5, rd_wen=0, imm=0x00000008, fmt=2. Send 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, fmt=3, rs1_en=1, rs2_en=1.
- Send 0x001000EF (jal x1,2048) → rd=1, imm=0x00000800, fmt=5. Send 0x00000000 → illegal=1, fmt=7, all enables 0.
- out_ready=0, three back-to-back instructions A, B, C:
  - A lands in main, B in skid, in_ready=0; C is held by upstream.
  - Raise out_ready → outputs A, B, C on consecutive cycles with no gaps or duplicates.
- With both entries full, assert flush for one cycle → out_valid=0 and in_ready=1 next cycle. An instruction offered in the flush cycle never appears.
- Assert rst_n=0 asynchronously mid-stall → out_valid drops immediately without waiting for a clock edge. After release: in_ready=1, all outputs 0, then normal decode resumes.
